// File: rtl/bean_field.sv
// Scrolling bean field: up to N_BEANS ground-line beans that move left each frame,
// spawn at the right edge after an LFSR-randomised gap, and vanish when eaten or missed.
module bean_field #(
   parameter int         N_BEANS   = 4,
   parameter int         BEAN_W    = 30,
   parameter int         BEAN_H    = 40,
   parameter int         GROUND_Y  = 380,
   parameter int         SCREEN_W  = 640,
   parameter int         SPEED     = 4,
   parameter int         SPAWN_MIN = 40,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic               run,
   input  logic               clear,
   input  logic [9:0]         x,
   input  logic [9:0]         y,
   input  logic [9:0]         goose_x,
   input  logic [9:0]         goose_y,
   input  logic [9:0]         goose_w,
   input  logic [9:0]         goose_h,
   output logic               bean,
   output logic               eat,
   output logic               miss,
   output logic [N_BEANS-1:0] active_mask
);

   localparam int TW = 16;

   logic [N_BEANS-1:0] active_reg;
   logic [9:0]         xpos_reg [N_BEANS];
   logic [TW-1:0]      timer_reg;
   logic [7:0]         lfsr_reg;
   logic               bean_reg, eat_reg, miss_reg;

   logic [N_BEANS-1:0] in_box, overlap, low, spawn_hot;
   logic               step, spawn_ok;

   // Bean vertical extent and goose box edges are shared by all slots.
   logic [10:0] bean_top, bean_bot, goose_r, goose_b;
   assign bean_top = 11'(GROUND_Y - BEAN_H);
   assign bean_bot = 11'(GROUND_Y);
   assign goose_r  = {1'b0, goose_x} + {1'b0, goose_w};
   assign goose_b  = {1'b0, goose_y} + {1'b0, goose_h};

   genvar gi;
   generate
      for (gi = 0; gi < N_BEANS; gi++) begin : g_slot
         logic [10:0] left, right;
         assign left  = {1'b0, xpos_reg[gi]};
         assign right = left + 11'(BEAN_W);
         assign in_box[gi]  = ({1'b0, x} >= left) && ({1'b0, x} <= right) &&
                              ({1'b0, y} >= bean_top) && ({1'b0, y} <= bean_bot);
         assign overlap[gi] = (left <= goose_r) && ({1'b0, goose_x} <= right) &&
                              (bean_top <= goose_b) && ({1'b0, goose_y} <= bean_bot);
         assign low[gi]     = (left < 11'(SPEED));
      end
   endgenerate

   assign step     = frame_tick && run && !clear;
   assign spawn_ok = step && (timer_reg == '0) && !(&active_reg);

   // Lowest-index free slot, judged on the pre-tick occupancy.
   always_comb begin
      logic found;
      spawn_hot = '0;
      found     = 1'b0;
      for (int i = 0; i < N_BEANS; i++) begin
         if (!active_reg[i] && !found) begin
            spawn_hot[i] = 1'b1;
            found        = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active_reg <= '0;
         for (int i = 0; i < N_BEANS; i++) xpos_reg[i] <= '0;
      end else if (clear) begin
         active_reg <= '0;
      end else if (step) begin
         for (int i = 0; i < N_BEANS; i++) begin
            if (spawn_ok && spawn_hot[i]) begin
               active_reg[i] <= 1'b1;
               xpos_reg[i]   <= 10'(SCREEN_W);
            end else if (active_reg[i]) begin
               if (overlap[i] || low[i])
                  active_reg[i] <= 1'b0;
               else
                  xpos_reg[i] <= xpos_reg[i] - 10'(SPEED);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer_reg <= TW'(SPAWN_MIN);
      end else if (clear) begin
         timer_reg <= TW'(SPAWN_MIN);
      end else if (step) begin
         if (timer_reg != '0)
            timer_reg <= timer_reg - 1'b1;
         else if (spawn_ok)
            timer_reg <= TW'(SPAWN_MIN) + {{(TW-5){1'b0}}, lfsr_reg[4:0]};
      end
   end

   // Fibonacci LFSR, taps 8,6,5,4; free-runs on frame_tick even while frozen.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         lfsr_reg <= LFSR_SEED;
      else if (frame_tick)
         lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bean_reg <= 1'b0;
         eat_reg  <= 1'b0;
         miss_reg <= 1'b0;
      end else begin
         bean_reg <= |(active_reg & in_box);
         eat_reg  <= step && |(active_reg & overlap);
         miss_reg <= step && |(active_reg & ~overlap & low);
      end
   end

   assign bean        = bean_reg;
   assign eat         = eat_reg;
   assign miss        = miss_reg;
   assign active_mask = active_reg;

endmodule

// File: tb/tb_bean_field.sv
// Randomised bench for bean_field against a frame-level model of the bean field rules.
module tb_bean_field;

   localparam int N         = 4;
   localparam int BEAN_W    = 30;
   localparam int BEAN_H    = 40;
   localparam int GROUND_Y  = 380;
   localparam int SCREEN_W  = 640;
   localparam int SPEED     = 4;
   localparam int SPAWN_MIN = 40;
   localparam int SEED      = 'hA5;

   logic         clk = 1'b0;
   logic         reset, frame_tick, run, clear;
   logic [9:0]   x, y, goose_x, goose_y, goose_w, goose_h;
   logic         bean, eat, miss;
   logic [N-1:0] active_mask;

   int tests = 0;
   int fails = 0;
   int n_eat = 0, n_miss = 0, n_spawn = 0;

   bean_field dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .run(run), .clear(clear),
      .x(x), .y(y), .goose_x(goose_x), .goose_y(goose_y), .goose_w(goose_w), .goose_h(goose_h),
      .bean(bean), .eat(eat), .miss(miss), .active_mask(active_mask)
   );

   always #5 clk = ~clk;

   // Model state: one entry per slot, plus spawn timer and LFSR.
   int m_act [N];
   int m_x   [N];
   int m_timer;
   int m_lfsr;

   task automatic check_val(input string tag, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int in_bean(input int bx, input int px, input int py);
      return (px >= bx && px <= bx + BEAN_W && py >= GROUND_Y - BEAN_H && py <= GROUND_Y) ? 1 : 0;
   endfunction

   function automatic int goose_hits(input int bx);
      int gx, gy, gw, gh;
      gx = int'(goose_x); gy = int'(goose_y); gw = int'(goose_w); gh = int'(goose_h);
      return (bx <= gx + gw && gx <= bx + BEAN_W &&
              GROUND_Y - BEAN_H <= gy + gh && gy <= GROUND_Y) ? 1 : 0;
   endfunction

   function automatic int model_mask();
      int m = 0;
      for (int i = 0; i < N; i++) if (m_act[i] != 0) m |= (1 << i);
      return m;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin m_act[i] = 0; m_x[i] = 0; end
      m_timer = SPAWN_MIN;
      m_lfsr  = SEED;
   endtask

   // One clock: compute expectations from the pre-edge state, clock, then compare.
   task automatic cycle(input int ft, input int rn, input int cl);
      int e_bean, e_eat, e_miss, free_idx, fb;
      frame_tick = ft[0]; run = rn[0]; clear = cl[0];
      e_bean = 0; e_eat = 0; e_miss = 0;
      for (int i = 0; i < N; i++)
         if (m_act[i] != 0 && in_bean(m_x[i], int'(x), int'(y)) != 0) e_bean = 1;
      if (cl != 0) begin
         for (int i = 0; i < N; i++) m_act[i] = 0;
         m_timer = SPAWN_MIN;
      end else if (ft != 0 && rn != 0) begin
         free_idx = -1;
         for (int i = N - 1; i >= 0; i--) if (m_act[i] == 0) free_idx = i;
         for (int i = 0; i < N; i++) begin
            if (m_act[i] != 0) begin
               if (goose_hits(m_x[i]) != 0) begin m_act[i] = 0; e_eat = 1; end
               else if (m_x[i] < SPEED)     begin m_act[i] = 0; e_miss = 1; end
               else m_x[i] -= SPEED;
            end
         end
         if (m_timer == 0) begin
            if (free_idx >= 0) begin
               m_act[free_idx] = 1;
               m_x[free_idx]   = SCREEN_W;
               m_timer         = SPAWN_MIN + (m_lfsr % 32);
               n_spawn++;
            end
         end else begin
            m_timer--;
         end
      end
      if (ft != 0) begin
         fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
         m_lfsr = ((m_lfsr << 1) | fb) & 255;
      end
      @(posedge clk);
      #1;
      check_val("bean", int'(bean), e_bean);
      check_val("eat", int'(eat), e_eat);
      check_val("miss", int'(miss), e_miss);
      check_val("mask", int'(active_mask), model_mask());
      n_eat  += e_eat;
      n_miss += e_miss;
      frame_tick = 1'b0;
      clear      = 1'b0;
   endtask

   // Half the time aim the pixel near an active bean so the box edges get exercised.
   task automatic pick_pixel();
      int i, px;
      i = $urandom_range(N - 1);
      if ($urandom_range(1) == 1 && m_act[i] != 0) begin
         px = m_x[i] + $urandom_range(BEAN_W + 6) - 3;
         if (px < 0) px = 0;
         if (px > 1023) px = 1023;
         x = 10'(px);
         y = 10'($urandom_range(GROUND_Y + 6, GROUND_Y - BEAN_H - 6));
      end else begin
         x = 10'($urandom_range(1023));
         y = 10'($urandom_range(1023));
      end
   endtask

   task automatic goose_far();
      goose_x = 10'd0; goose_y = 10'd0; goose_w = 10'd0; goose_h = 10'd0;
   endtask

   initial begin
      reset = 1'b1; frame_tick = 1'b0; run = 1'b0; clear = 1'b0;
      x = '0; y = '0;
      goose_far();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_mask", int'(active_mask), 0);
      check_val("rst_bean", int'(bean), 0);
      check_val("rst_eat", int'(eat), 0);
      check_val("rst_miss", int'(miss), 0);
      #2 reset = 1'b0;

      // Fresh start: nothing for 40 ticks, first spawn lands in slot 0 on tick 41.
      for (int t = 1; t <= 41; t++) begin
         pick_pixel();
         cycle(1, 1, 0);
         if (t == 40) check_val("t1_pre_spawn", int'(active_mask), 0);
         if (t == 41) check_val("t1_spawn", int'(active_mask), 1);
         pick_pixel();
         cycle(0, 1, 0);
      end

      for (int it = 0; it < 1500; it++) begin
         int rn;
         if (it % 64 == 0) begin
            if ($urandom_range(1) == 0) goose_far();
            else begin
               goose_x = 10'($urandom_range(700));
               goose_y = 10'($urandom_range(GROUND_Y, GROUND_Y - BEAN_H - 40));
               goose_w = 10'($urandom_range(60));
               goose_h = 10'($urandom_range(60));
            end
         end
         if (it == 700) begin
            reset = 1'b1;
            #1;
            check_val("async_rst_mask", int'(active_mask), 0);
            check_val("async_rst_bean", int'(bean), 0);
            model_reset();
            @(posedge clk);
            #2 reset = 1'b0;
         end
         rn = ($urandom_range(9) != 0) ? 1 : 0;
         pick_pixel();
         cycle(1, rn, ($urandom_range(149) == 0) ? 1 : 0);
         $display("[TB] tick %0d run=%0d mask=%b eat=%0b miss=%0b bean=%0b",
                  it, rn, active_mask, eat, miss, bean);
         for (int k = $urandom_range(2); k > 0; k--) begin
            pick_pixel();
            cycle(0, rn, ($urandom_range(299) == 0) ? 1 : 0);
         end
      end

      // clear wins over a tick that would otherwise eat every bean.
      goose_x = 10'd0; goose_w = 10'd700; goose_y = 10'd340; goose_h = 10'd40;
      pick_pixel();
      cycle(1, 1, 1);
      check_val("clear_mask", int'(active_mask), 0);
      check_val("clear_eat", int'(eat), 0);

      $display("[TB] model saw %0d eats, %0d misses, %0d spawns", n_eat, n_miss, n_spawn);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
